// File: rtl/fetch_unit_l1.sv
// fetch_unit_l1: in-order sequential instruction fetch stage.
// Issues word reads, buffers responses, hands {inst,pc,seq} to decode.
module fetch_unit_l1 #(
  parameter logic [31:0] p_rst_addr      = 32'h0000_0200,
  parameter int          p_num_in_flight = 4,
  parameter int          p_seq_num_bits  = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      mem_req_val,
  input  logic                      mem_req_rdy,
  output logic [31:0]               mem_req_addr,
  input  logic                      mem_resp_val,
  output logic                      mem_resp_rdy,
  input  logic [31:0]               mem_resp_data,
  output logic                      D_val,
  input  logic                      D_rdy,
  output logic [31:0]               D_inst,
  output logic [31:0]               D_pc,
  output logic [p_seq_num_bits-1:0] D_seq_num
);

  localparam int N  = p_num_in_flight;
  localparam int PW = $clog2(N);
  localparam int CW = PW + 1;

  localparam logic [CW-1:0] FULL = CW'(N);
  localparam logic [PW-1:0] LAST = PW'(N - 1);

  logic [31:0]   pc_q;
  logic          started_q;
  logic [CW-1:0] credits_q;
  logic [CW-1:0] icnt_q;

  logic [p_seq_num_bits-1:0] seq_q;

  logic [31:0]   pc_mem   [N];
  logic [31:0]   inst_mem [N];
  logic [PW-1:0] pc_wr_q;
  logic [PW-1:0] pc_rd_q;
  logic [PW-1:0] in_wr_q;
  logic [PW-1:0] in_rd_q;

  logic req_fire;
  logic d_fire;
  logic resp_push;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign mem_req_val  = started_q & (credits_q < FULL);
  assign mem_req_addr = pc_q;
  assign mem_resp_rdy = started_q;

  assign D_val     = (icnt_q != '0);
  assign D_inst    = inst_mem[in_rd_q];
  assign D_pc      = pc_mem[pc_rd_q];
  assign D_seq_num = seq_q;

  assign req_fire  = mem_req_val & mem_req_rdy;
  assign d_fire    = D_val & D_rdy;
  assign resp_push = mem_resp_val;

  // Fetch PC, start flag and program-order tag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q      <= p_rst_addr;
      started_q <= 1'b0;
      seq_q     <= '0;
    end else begin
      started_q <= 1'b1;
      if (req_fire)
        pc_q <= pc_q + 32'd4;
      if (d_fire)
        seq_q <= seq_q + 1'b1;
    end
  end

  // Credits track requests not yet handed to decode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credits_q <= '0;
    end else begin
      unique case ({req_fire, d_fire})
        2'b10:   credits_q <= credits_q + CW'(1);
        2'b01:   credits_q <= credits_q - CW'(1);
        default: credits_q <= credits_q;
      endcase
    end
  end

  // PC FIFO pointers: push on request, pop on decode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_wr_q <= '0;
      pc_rd_q <= '0;
    end else begin
      if (req_fire)
        pc_wr_q <= nxt(pc_wr_q);
      if (d_fire)
        pc_rd_q <= nxt(pc_rd_q);
    end
  end

  // Instruction FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_wr_q <= '0;
      in_rd_q <= '0;
      icnt_q  <= '0;
    end else begin
      if (resp_push)
        in_wr_q <= nxt(in_wr_q);
      if (d_fire)
        in_rd_q <= nxt(in_rd_q);
      unique case ({resp_push, d_fire})
        2'b10:   icnt_q <= icnt_q + CW'(1);
        2'b01:   icnt_q <= icnt_q - CW'(1);
        default: icnt_q <= icnt_q;
      endcase
    end
  end

  // FIFO storage; contents are meaningless unless counted valid.
  always_ff @(posedge clk) begin
    if (req_fire)
      pc_mem[pc_wr_q] <= pc_q;
    if (resp_push)
      inst_mem[in_wr_q] <= mem_resp_data;
  end

`ifndef SYNTHESIS
  resp_has_request: assert property (
    @(posedge clk) disable iff (!rst)
    mem_resp_val |-> (credits_q > icnt_q)
  );
`endif

endmodule

// File: tb/tb_fetch_unit_l1.sv
// tb_fetch_unit_l1: scoreboard bench for fetch_unit_l1.
// 1-cycle memory returns ~addr; seq tag is 2 bits wide.
module tb_fetch_unit_l1;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req_val;
  logic        mem_req_rdy;
  logic [31:0] mem_req_addr;
  logic        mem_resp_val;
  logic        mem_resp_rdy;
  logic [31:0] mem_resp_data;
  logic        D_val;
  logic        D_rdy;
  logic [31:0] D_inst;
  logic [31:0] D_pc;
  logic [1:0]  D_seq_num;

  typedef struct packed {
    logic [31:0] pc;
    logic [1:0]  seq;
  } exp_t;

  exp_t sbq[$];
  logic [1:0] exp_seq;

  int n_chk  = 0;
  int n_fail = 0;
  int nreq   = 0;
  int ndone  = 0;

  fetch_unit_l1 #(
    .p_rst_addr     (32'h0000_0200),
    .p_num_in_flight(4),
    .p_seq_num_bits (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_req_val  (mem_req_val),
    .mem_req_rdy  (mem_req_rdy),
    .mem_req_addr (mem_req_addr),
    .mem_resp_val (mem_resp_val),
    .mem_resp_rdy (mem_resp_rdy),
    .mem_resp_data(mem_resp_data),
    .D_val        (D_val),
    .D_rdy        (D_rdy),
    .D_inst       (D_inst),
    .D_pc         (D_pc),
    .D_seq_num    (D_seq_num)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // 1-cycle memory, reset by the same rst.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_resp_val  <= 1'b0;
      mem_resp_data <= '0;
    end else begin
      mem_resp_val  <= mem_req_val & mem_req_rdy;
      mem_resp_data <= ~mem_req_addr;
    end
  end

  // Scoreboard: push on request transfer, pop on decode transfer.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      sbq.delete();
      exp_seq = '0;
    end else begin
      if (D_val && D_rdy) begin
        if (sbq.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("d_pc", D_pc, e.pc);
          chk("d_inst", D_inst, ~e.pc);
          chk("d_seq", 32'(D_seq_num), 32'(e.seq));
        end
        ndone++;
      end
      if (mem_req_val && mem_req_rdy) begin
        sbq.push_back('{pc: mem_req_addr, seq: exp_seq});
        exp_seq = exp_seq + 2'd1;
        nreq++;
      end
    end
  end

  initial begin
    int n0;
    int waited;
    rst         = 1'b0;
    mem_req_rdy = 1'b1;
    D_rdy       = 1'b1;

    repeat (3) begin
      step();
      chk("rst_req_val", 32'(mem_req_val), 32'd0);
      chk("rst_d_val", 32'(D_val), 32'd0);
      chk("rst_resp_rdy", 32'(mem_resp_rdy), 32'd0);
      chk("rst_addr", mem_req_addr, 32'h200);
    end
    rst = 1'b1;
    #1;
    chk("rel_req_val", 32'(mem_req_val), 32'd0);
    chk("rel_d_val", 32'(D_val), 32'd0);

    step();
    chk("first_req_val", 32'(mem_req_val), 32'd1);
    chk("first_addr", mem_req_addr, 32'h200);
    chk("resp_rdy", 32'(mem_resp_rdy), 32'd1);
    step();
    chk("fill_d_val", 32'(D_val), 32'd0);
    step();
    chk("first_d_val", 32'(D_val), 32'd1);
    chk("first_d_pc", D_pc, 32'h200);

    n0 = ndone;
    repeat (20) step();
    chk("throughput", 32'(ndone - n0), 32'd20);

    rst   = 1'b0;
    D_rdy = 1'b0;
    #1;
    chk("midrst_d_val", 32'(D_val), 32'd0);
    chk("midrst_req_val", 32'(mem_req_val), 32'd0);
    step();
    step();
    rst = 1'b1;
    step();
    n0 = nreq;
    repeat (10) step();
    chk("bp_reqs", 32'(nreq - n0), 32'd4);
    chk("bp_req_val", 32'(mem_req_val), 32'd0);
    chk("bp_d_val", 32'(D_val), 32'd1);
    chk("bp_d_pc", D_pc, 32'h200);
    chk("bp_d_seq", 32'(D_seq_num), 32'd0);
    D_rdy = 1'b1;
    #1;
    chk("bp_still_off", 32'(mem_req_val), 32'd0);
    step();
    chk("bp_resume_val", 32'(mem_req_val), 32'd1);
    chk("bp_resume_addr", mem_req_addr, 32'h210);

    rst         = 1'b0;
    mem_req_rdy = 1'b0;
    step();
    rst = 1'b1;
    step();
    repeat (5) begin
      step();
      chk("stall_addr", mem_req_addr, 32'h200);
      chk("stall_d_val", 32'(D_val), 32'd0);
      chk("stall_req_val", 32'(mem_req_val), 32'd1);
    end

    n0 = ndone;
    repeat (300) begin
      mem_req_rdy = 1'($urandom_range(0, 1));
      D_rdy       = ($urandom_range(0, 3) != 0);
      step();
    end
    chk("rand_progress", 32'(ndone - n0 > 50), 32'd1);

    mem_req_rdy = 1'b0;
    D_rdy       = 1'b1;
    waited      = 0;
    while ((sbq.size() != 0 || D_val) && waited < 50) begin
      step();
      waited++;
    end
    chk("drain_sb", 32'(sbq.size()), 32'd0);
    chk("drain_d_val", 32'(D_val), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
